// File: rtl/pc_unit.sv
// Fetch-stage program counter with prioritised redirects (exception, stall,
// register jump, return, jump/call, branch) and a circular return-address stack.
module pc_unit #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned INCR         = 1,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned EXC_VECTOR   = 32'h10,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          exception,
    input  logic                          Branch,
    input  logic                          Zero,
    input  logic [ADDR_WIDTH-1:0]         extended,
    input  logic                          jump,
    input  logic                          call,
    input  logic [ADDR_WIDTH-1:0]         jump_target,
    input  logic                          jr,
    input  logic [ADDR_WIDTH-1:0]         jr_target,
    input  logic                          ret,
    output logic [ADDR_WIDTH-1:0]         IM_Address,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_empty,
    output logic                          ras_overflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] INCR_C  = ADDR_WIDTH'(INCR);
    localparam logic [ADDR_WIDTH-1:0] RESET_C = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] EXC_C   = ADDR_WIDTH'(EXC_VECTOR);
    localparam logic [CNT_W-1:0]      FULL_C  = CNT_W'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]      ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  empty_r;
    logic                  overflow_r;

    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic [ADDR_WIDTH-1:0] seq_pc_s;
    logic [PTR_W-1:0]      ptr_next_s;
    logic [CNT_W-1:0]      count_next_s;
    logic                  overflow_next_s;
    logic                  push_s;
    logic                  pop_s;

    assign seq_pc_s = pc_r + INCR_C;

    // Next-PC selection by strict priority; only the winning source may push or pop.
    always_comb begin
        pc_next_s = seq_pc_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        if (exception) begin
            pc_next_s = EXC_C;
        end else if (stall) begin
            pc_next_s = pc_r;
        end else if (jr) begin
            pc_next_s = jr_target;
        end else if (ret) begin
            // An empty stack falls back to the register target rather than stale data.
            if (count_r != {CNT_W{1'b0}}) begin
                pc_next_s = ras_mem_r[ptr_r - PTR_W'(1)];
                pop_s     = 1'b1;
            end else begin
                pc_next_s = jr_target;
            end
        end else if (jump) begin
            pc_next_s = jump_target;
            push_s    = call;
        end else if (Branch && Zero) begin
            pc_next_s = seq_pc_s + extended;
        end else begin
            pc_next_s = seq_pc_s;
        end
    end

    // Stack bookkeeping: a push onto a full stack overwrites the oldest entry.
    always_comb begin
        ptr_next_s      = ptr_r;
        count_next_s    = count_r;
        overflow_next_s = overflow_r;
        if (push_s) begin
            ptr_next_s = ptr_r + PTR_W'(1);
            if (count_r == FULL_C) begin
                overflow_next_s = 1'b1;
            end else begin
                count_next_s = count_r + CNT_W'(1);
            end
        end else if (pop_s) begin
            ptr_next_s   = ptr_r - PTR_W'(1);
            count_next_s = count_r - CNT_W'(1);
        end else begin
            ptr_next_s   = ptr_r;
            count_next_s = count_r;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r       <= RESET_C;
            ptr_r      <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            pc_r       <= pc_next_s;
            ptr_r      <= ptr_next_s;
            count_r    <= count_next_s;
            empty_r    <= (count_next_s == {CNT_W{1'b0}});
            overflow_r <= overflow_next_s;
        end
    end

    // Stack storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            ras_mem_r[ptr_r] <= seq_pc_s;
        end
    end

    assign IM_Address   = pc_r;
    assign ras_count    = count_r;
    assign ras_empty    = empty_r;
    assign ras_overflow = overflow_r;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic against a
// queue-based reference model of the PC and return stack.
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, exception, Branch, Zero, jump, call, jr, ret;
    logic [31:0] extended, jump_target, jr_target;
    logic [31:0] IM_Address;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic        m_ovf;

    pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .exception(exception),
        .Branch(Branch), .Zero(Zero), .extended(extended), .jump(jump),
        .call(call), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
        .ret(ret), .IM_Address(IM_Address), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_overflow(ras_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        stall = 1'b0; exception = 1'b0; Branch = 1'b0; Zero = 1'b0;
        jump = 1'b0; call = 1'b0; jr = 1'b0; ret = 1'b0;
        extended = 32'd0; jump_target = 32'd0; jr_target = 32'd0;
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        m_ras.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_push(input logic [31:0] v);
        m_ras.push_back(v);
        if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_step();
        if (exception)            m_pc = 32'h10;
        else if (stall)           m_pc = m_pc;
        else if (jr)              m_pc = jr_target;
        else if (ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else                  m_pc = jr_target;
        end else if (jump) begin
            if (call) model_push(m_pc + 32'd1);
            m_pc = jump_target;
        end else if (Branch && Zero) m_pc = m_pc + 32'd1 + extended;
        else                      m_pc = m_pc + 32'd1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    IM_Address,          m_pc);
        check({tag, ".cnt"},   32'(ras_count),      32'(m_ras.size()));
        check({tag, ".empty"}, 32'(ras_empty),      32'(m_ras.size() == 0));
        check({tag, ".ovf"},   32'(ras_overflow),   32'(m_ovf));
    endtask

    // One clock edge, then compare a moment later.
    task automatic step(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset between edges; output must clear before the next edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("async_rst.pc", IM_Address, 32'd0);
        check("async_rst.cnt", 32'(ras_count), 32'd0);
        #1;
        reset = 1'b0;
    endtask

    task automatic go_to(input logic [31:0] a);
        clr(); jump = 1'b1; jump_target = a;
        step("goto");
        clr();
    endtask

    task automatic do_call(input logic [31:0] a);
        clr(); jump = 1'b1; call = 1'b1; jump_target = a;
        step("call");
        clr();
    endtask

    task automatic do_ret(input logic [31:0] jt, input logic [31:0] exp);
        clr(); ret = 1'b1; jr_target = jt;
        step("ret");
        check("ret.direct", IM_Address, exp);
        clr();
    endtask

    initial begin
        clr();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all("reset");

        // Sequential counting and mid-stall reset
        step("seq1"); check("seq1.direct", IM_Address, 32'd1);
        step("seq2"); check("seq2.direct", IM_Address, 32'd2);
        step("seq3"); check("seq3.direct", IM_Address, 32'd3);
        stall = 1'b1;
        step("stall_pre_rst");
        do_reset();
        clr();

        // Branches and wrap-around
        go_to(32'd5);
        Branch = 1'b1; Zero = 1'b1; extended = -32'sd3;
        step("br_taken"); check("br_taken.direct", IM_Address, 32'd3);
        go_to(32'd5);
        Branch = 1'b1; Zero = 1'b0; extended = -32'sd3;
        step("br_not"); check("br_not.direct", IM_Address, 32'd6);
        go_to(32'hFFFF_FFFF);
        step("wrap"); check("wrap.direct", IM_Address, 32'd0);

        // Call/return and empty-stack return
        go_to(32'd8);
        do_call(32'd40);
        check("call.direct", IM_Address, 32'd40);
        check("call.cnt", 32'(ras_count), 32'd1);
        do_ret(32'd0, 32'd9);
        check("ret.empty", 32'(ras_empty), 32'd1);
        do_ret(32'd77, 32'd77);

        // Nested calls overflowing a four-deep stack
        do_reset();
        clr();
        do_call(32'd10); do_call(32'd20); do_call(32'd30);
        do_call(32'd40); do_call(32'd50);
        check("ovf.flag", 32'(ras_overflow), 32'd1);
        check("ovf.cnt", 32'(ras_count), 32'd4);
        do_ret(32'd0, 32'd41);
        do_ret(32'd0, 32'd31);
        do_ret(32'd0, 32'd21);
        do_ret(32'd0, 32'd11);
        do_ret(32'd99, 32'd99);
        check("ovf.sticky", 32'(ras_overflow), 32'd1);

        // Stall blocks everything except exception
        do_reset();
        go_to(32'd12);
        stall = 1'b1; jump = 1'b1; call = 1'b1; jump_target = 32'd40;
        step("stall"); check("stall.direct", IM_Address, 32'd12);
        check("stall.cnt", 32'(ras_count), 32'd0);
        exception = 1'b1;
        step("exc"); check("exc.direct", IM_Address, 32'd16);
        clr();

        // jr beats jump/call/branch
        jr = 1'b1; jr_target = 32'd100; jump = 1'b1; call = 1'b1;
        jump_target = 32'd40; Branch = 1'b1; Zero = 1'b1; extended = 32'd7;
        step("prio"); check("prio.direct", IM_Address, 32'd100);
        check("prio.cnt", 32'(ras_count), 32'd0);
        clr();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            stall       = ($urandom_range(7) == 0);
            exception   = ($urandom_range(15) == 0);
            jr          = ($urandom_range(7) == 0);
            ret         = ($urandom_range(3) == 0);
            jump        = ($urandom_range(2) == 0);
            call        = $urandom_range(1);
            Branch      = ($urandom_range(2) == 0);
            Zero        = $urandom_range(1);
            extended    = 32'($signed($urandom_range(64)) - 32);
            jump_target = $urandom;
            jr_target   = $urandom;
            step("rand");
            if ($urandom_range(99) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit. It is the next generation of the core's simple sequential/branch PC. It adds:
- stall
- absolute jump
- register jump
- call/return with a hardware return-address stack (RAS)
- exception redirect

It sits at the front of the fetch stage. It drives the instruction-memory word address every cycle.

Parameters:
ADDR_WIDTH, 32, width of PC and all address/offset inputs
INCR, 1, sequential increment (word-addressed instruction memory)
RESET_VECTOR, 0, PC value on reset
EXC_VECTOR, 'h10, PC value loaded on exception
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC (fetch bubble)
exception  in  1  redirect to EXC_VECTOR
Branch  in  1  instruction is a conditional branch
Zero  in  1  ALU zero flag; branch taken = Branch && Zero
extended  in  ADDR_WIDTH  signed, sign-extended branch offset
jump  in  1  absolute jump to jump_target
call  in  1  qualifies jump: push return address
jump_target  in  ADDR_WIDTH  absolute jump address
jr  in  1  register jump to jr_target
jr_target  in  ADDR_WIDTH  register-supplied address
ret  in  1  return: pop RAS
IM_Address  out  ADDR_WIDTH  current PC (registered)
ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
ras_empty  out  1  ras_count==0
ras_overflow  out  1  sticky: a push overwrote the oldest entry

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc=RESET_VECTOR
  - RAS count=0, RAS pointer=0, entries don't-care
  - ras_overflow=0
  - takes effect immediately, not at the next edge
- IM_Address=pc, always registered. It is never a combinational function of the control inputs.
- One update per rising edge. Next pc is selected by strict priority, highest first:
  1. exception: pc<=EXC_VECTOR; RAS unchanged; overrides stall.
  2. stall: pc holds; no RAS push/pop regardless of other inputs.
  3. jr: pc<=jr_target.
  4. ret:
     - RAS non-empty: pc<=RAS top; count decrements.
     - RAS empty: pc<=jr_target; count stays 0.
  5. jump: pc<=jump_target.
     - If call=1, push pc+INCR.
     - call without jump is ignored.
  6. Branch&&Zero: pc<=pc+INCR+extended.
  7. else: pc<=pc+INCR.
- Only the selected source has side effects. Example: jump&&call with jr=1 performs jr and does not push.
- Arithmetic:
  - all sums are modulo 2^ADDR_WIDTH; wrap-around is silent
  - extended is two's complement, so negative offsets branch backward
  - pushed return address = pc+INCR, also wrapped
- RAS is a circular buffer of RAS_DEPTH entries:
  - push writes at the top pointer and advances it
  - when count<RAS_DEPTH, count increments
  - when full, the oldest entry is overwritten, count stays RAS_DEPTH, and ras_overflow sets (cleared only by reset)
  - pop retreats the pointer
- ras_count and ras_empty are registered and reflect state after the last edge.
- Latency: a redirect input sampled at edge N appears on IM_Address right after edge N.

Test Plan:
1. Reset, then 3 clocks with all controls 0.
   - IM_Address: 0 -> 1 -> 2 -> 3.
   - Assert reset between edges: IM_Address=0 immediately, before the next edge.
2. At pc=5, Branch=1, Zero=1, extended=-3 -> next pc=3.
   - Same with Zero=0 -> pc=6.
   - At pc=2^32-1 with no control -> pc=0.
3. At pc=8, jump=1, call=1, jump_target=40 -> pc=40, ras_count=1.
   - Then ret=1 -> pc=9, ras_empty=1.
   - ret on empty with jr_target=77 -> pc=77.
4. Five nested calls from pc=0,10,20,30,40 (depth 4) -> ras_overflow=1, ras_count=4.
   - Four rets return 41, 31, 21, 11.
   - Fifth ret uses jr_target.
5. At pc=12, stall=1 with jump=1, call=1 -> pc holds 12, ras_count unchanged.
   - stall=1 with exception=1 -> pc=16 (EXC_VECTOR).
6. jr=1 (jr_target=100), jump=1, call=1, Branch=1, Zero=1 all in the same cycle -> pc=100, no push.
